// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and line levels.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Level the TX line rests at when no word is in flight.
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer_p.sv
// Parametrised UART TX parallel-to-serial shifter. Loads a word through a
// valid/ready handshake, emits one bit per baud tick in the selected order,
// computes the word parity at load, and supports zero-bubble reloads on the
// final tick of the current word.
module uart_tx_serializer_p
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,  // 2..16
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PAR_ODD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done,
  output logic                  par_bit
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  ser_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  ser_data_q, ser_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  par_q, par_d;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  next_bit;
  logic                  first_bit;
  logic                  last_tick;
  logic                  accept;

  // Bit-order datapath. The bit leaving the register is recirculated into the
  // vacated end; it is never presented again, and recirculating it keeps every
  // register bit in use.
  if (MSB_FIRST) begin : g_msb_first
    assign shifted   = {sreg_q[DATA_WIDTH-2:0], sreg_q[DATA_WIDTH-1]};
    assign next_bit  = sreg_q[DATA_WIDTH-2];
    assign first_bit = p_data[DATA_WIDTH-1];
  end else begin : g_lsb_first
    assign shifted   = {sreg_q[0], sreg_q[DATA_WIDTH-1:1]};
    assign next_bit  = sreg_q[1];
    assign first_bit = p_data[0];
  end

  // Ready is open in IDLE, and on the final tick of a word so a new word can
  // follow without an idle gap. It never depends on ld_valid.
  assign last_tick = (state_q == SHIFT) && shift_en && (cnt_q == LAST_IDX);
  assign ld_ready  = (state_q == IDLE) || last_tick;
  assign accept    = ld_valid && ld_ready;

  // Next-state and next-output logic for the shifter FSM.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    ser_data_d = ser_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    par_d      = par_q;

    unique case (state_q)
      IDLE: begin
        // shift_en is ignored here; only a load leaves IDLE.
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q == LAST_IDX) begin
            done_d     = 1'b1;
            state_d    = IDLE;
            busy_d     = 1'b0;
            ser_data_d = UART_IDLE_LEVEL;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            sreg_d     = shifted;
            ser_data_d = next_bit;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the end-of-word return to IDLE, which gives the
    // back-to-back case for free.
    if (accept) begin
      sreg_d     = p_data;
      cnt_d      = '0;
      par_d      = (^p_data) ^ PAR_ODD;
      ser_data_d = first_bit;
      busy_d     = 1'b1;
      state_d    = SHIFT;
    end
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      ser_data_q <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values computed before the edge.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      par_q      <= par_d;
    end
  end

  assign ser_data = ser_data_q;
  assign ser_busy = busy_q;
  assign ser_done = done_q;
  assign par_bit  = par_q;

endmodule : uart_tx_serializer_p

// File: tb/tb_uart_tx_serializer_p.sv
// Bench for uart_tx_serializer_p. Three instances (W=8 LSB/even, W=8 MSB/odd,
// W=5 LSB/even) share one set of inputs. A word-level reference model tracks
// each instance as "word, index of bit on the line, busy" and is compared
// every cycle; scenario tasks add directed checks of literal bit sequences.
module tb_uart_tx_serializer_p;

  localparam int N_DUT = 3;
  localparam int CFG_W   [N_DUT] = '{8, 8, 5};
  localparam bit CFG_MSB [N_DUT] = '{1'b0, 1'b1, 1'b0};
  localparam bit CFG_ODD [N_DUT] = '{1'b0, 1'b1, 1'b0};

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [15:0] p_data;
  logic        shift_en;

  logic [N_DUT-1:0] ld_ready;
  logic [N_DUT-1:0] ser_data;
  logic [N_DUT-1:0] ser_busy;
  logic [N_DUT-1:0] ser_done;
  logic [N_DUT-1:0] par_bit;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  uart_tx_serializer_p #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PAR_ODD(1'b0)) u_lsb8 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready[0]),
    .p_data(p_data[7:0]), .shift_en(shift_en), .ser_data(ser_data[0]),
    .ser_busy(ser_busy[0]), .ser_done(ser_done[0]), .par_bit(par_bit[0]));

  uart_tx_serializer_p #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PAR_ODD(1'b1)) u_msb8 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready[1]),
    .p_data(p_data[7:0]), .shift_en(shift_en), .ser_data(ser_data[1]),
    .ser_busy(ser_busy[1]), .ser_done(ser_done[1]), .par_bit(par_bit[1]));

  uart_tx_serializer_p #(.DATA_WIDTH(5), .MSB_FIRST(1'b0), .PAR_ODD(1'b0)) u_w5 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready[2]),
    .p_data(p_data[4:0]), .shift_en(shift_en), .ser_data(ser_data[2]),
    .ser_busy(ser_busy[2]), .ser_done(ser_done[2]), .par_bit(par_bit[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [15:0] m_word [N_DUT];
  int          m_idx  [N_DUT];
  logic        m_busy [N_DUT];
  logic        m_par  [N_DUT];
  logic        m_done [N_DUT];

  function automatic logic [15:0] word_mask(int i);
    return 16'((32'd1 << CFG_W[i]) - 1);
  endfunction

  function automatic logic m_last(int i);
    return m_busy[i] && shift_en && (m_idx[i] == CFG_W[i] - 1);
  endfunction

  function automatic logic exp_ready(int i);
    return !m_busy[i] || m_last(i);
  endfunction

  function automatic logic exp_data(int i);
    if (!m_busy[i]) return 1'b1;
    if (CFG_MSB[i]) return m_word[i][CFG_W[i] - 1 - m_idx[i]];
    return m_word[i][m_idx[i]];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DUT; i++) begin
        m_word[i] <= '0;
        m_idx[i]  <= 0;
        m_busy[i] <= 1'b0;
        m_par[i]  <= 1'b0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_DUT; i++) begin
        m_done[i] <= m_last(i);
        if (ld_valid && exp_ready(i)) begin
          m_word[i] <= p_data & word_mask(i);
          m_idx[i]  <= 0;
          m_busy[i] <= 1'b1;
          m_par[i]  <= (^(p_data & word_mask(i))) ^ CFG_ODD[i];
        end else if (m_busy[i] && shift_en) begin
          if (m_last(i)) m_busy[i] <= 1'b0;
          else           m_idx[i]  <= m_idx[i] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (ser_data[i] !== exp_data(i)) begin
          errors++;
          $display("FAIL mon_ser_data dut%0d t=%0t got %b exp %b", i, $time, ser_data[i], exp_data(i));
        end
        checks++;
        if (ser_busy[i] !== m_busy[i]) begin
          errors++;
          $display("FAIL mon_ser_busy dut%0d t=%0t got %b exp %b", i, $time, ser_busy[i], m_busy[i]);
        end
        checks++;
        if (ser_done[i] !== m_done[i]) begin
          errors++;
          $display("FAIL mon_ser_done dut%0d t=%0t got %b exp %b", i, $time, ser_done[i], m_done[i]);
        end
        checks++;
        if (par_bit[i] !== m_par[i]) begin
          errors++;
          $display("FAIL mon_par_bit dut%0d t=%0t got %b exp %b", i, $time, par_bit[i], m_par[i]);
        end
        checks++;
        if (ld_ready[i] !== exp_ready(i)) begin
          errors++;
          $display("FAIL mon_ld_ready dut%0d t=%0t got %b exp %b", i, $time, ld_ready[i], exp_ready(i));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc();
    shift_en = 1'b1;
    cyc();
    shift_en = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    cyc();
    ld_valid = 1'b1;
    p_data   = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic drain();
    ld_valid = 1'b0;
    repeat (20) tick();
  endtask

  // Walks instance d from bit 'first' to the end of its word, checking each
  // bit against seq (bit k of seq is the k-th bit on the line), then the
  // end-of-word done pulse and return to idle.
  task automatic expect_serial(input int d, input int first, input int n,
                               input logic [15:0] seq, input int gap, input string tag);
    for (int k = first; k < n; k++) begin
      checks++;
      if (ser_data[d] !== seq[k]) begin
        errors++;
        $display("FAIL %s bit%0d got %b exp %b", tag, k, ser_data[d], seq[k]);
      end
      checks++;
      if (ser_busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_bit%0d got %b exp 1", tag, k, ser_busy[d]);
      end
      tick();
      if (k < n - 1) repeat (gap) cyc();
    end
    checks++;
    if (ser_done[d] !== 1'b1 || ser_data[d] !== 1'b1 || ser_busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s end done/data/busy got %b%b%b exp 110", tag, ser_done[d], ser_data[d], ser_busy[d]);
    end
    cyc();
    checks++;
    if (ser_done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got %b exp 0", tag, ser_done[d]);
    end
  endtask

  task automatic test_reset();
    cyc();
    checks++;
    if (ser_data !== 3'b111 || ser_busy !== 3'b000 || ser_done !== 3'b000 ||
        par_bit !== 3'b000 || ld_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_values got data=%b busy=%b done=%b par=%b rdy=%b exp 111 000 000 000 111",
               ser_data, ser_busy, ser_done, par_bit, ld_ready);
    end
    mon_en = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_lsb_a5();
    load(16'h00A5);
    checks++;
    if (par_bit[0] !== 1'b0) begin
      errors++;
      $display("FAIL lsb_a5_parity got %b exp 0", par_bit[0]);
    end
    expect_serial(0, 0, 8, 16'h00A5, 3, "lsb_a5");
    drain();
  endtask

  task automatic test_msb_odd();
    load(16'h0081);
    checks++;
    if (par_bit[1] !== 1'b1) begin
      errors++;
      $display("FAIL msb_81_parity got %b exp 1", par_bit[1]);
    end
    expect_serial(1, 0, 8, 16'h0081, 3, "msb_81");
    drain();
  endtask

  task automatic test_w5();
    load(16'h0016);
    checks++;
    if (par_bit[2] !== 1'b1) begin
      errors++;
      $display("FAIL w5_parity got %b exp 1", par_bit[2]);
    end
    expect_serial(2, 0, 5, 16'h0016, 2, "w5_16");
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic [7:0] w1;
    w0 = 8'h0F;
    w1 = 8'hF0;
    cyc();
    ld_valid = 1'b1;
    p_data   = 16'(w0);
    cyc();
    p_data   = 16'(w1);  // request held; accepted only on the 8th tick
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ser_data[0] !== w0[k] || ser_busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_w0 bit%0d got data=%b busy=%b exp %b 1", k, ser_data[0], ser_busy[0], w0[k]);
      end
      tick();
      if (k < 7) cyc();
    end
    ld_valid = 1'b0;
    checks++;
    if (ser_done[0] !== 1'b1 || ser_busy[0] !== 1'b1 || par_bit[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload done/busy/par got %b%b%b exp 110", ser_done[0], ser_busy[0], par_bit[0]);
    end
    expect_serial(0, 0, 8, 16'(w1), 1, "b2b_w1");
    drain();
  endtask

  task automatic test_ignored();
    tick();
    checks++;
    if (ser_busy !== 3'b000 || ser_data !== 3'b111) begin
      errors++;
      $display("FAIL idle_tick got busy=%b data=%b exp 000 111", ser_busy, ser_data);
    end
    cyc();
    ld_valid = 1'b1;
    p_data   = 16'h003C;
    shift_en = 1'b1;
    cyc();
    ld_valid = 1'b0;
    shift_en = 1'b0;
    checks++;
    if (ser_data[0] !== 1'b0 || ser_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_tick_ignored got data=%b busy=%b exp 0 1", ser_data[0], ser_busy[0]);
    end
    tick();
    tick();
    cyc();
    ld_valid = 1'b1;
    p_data   = 16'hFFFF;
    #1;
    checks++;
    if (ld_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL midword_ready got %b exp 0", ld_ready[0]);
    end
    cyc();
    ld_valid = 1'b0;
    p_data   = 16'h0000;
    expect_serial(0, 2, 8, 16'h003C, 2, "ignored_3c");
    drain();
  endtask

  task automatic test_reset_midword();
    load(16'h00FF);
    repeat (3) tick();
    cyc();
    reset = 1'b1;
    #1;
    checks++;
    if (ser_data[0] !== 1'b1 || ser_busy[0] !== 1'b0 || ser_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort data/busy/done got %b%b%b exp 100", ser_data[0], ser_busy[0], ser_done[0]);
    end
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      checks++;
      if (ser_done !== 3'b000) begin
        errors++;
        $display("FAIL reset_no_done c%0d got %b exp 000", c, ser_done);
      end
    end
    load(16'h0001);
    expect_serial(0, 0, 8, 16'h0001, 1, "post_reset_01");
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cyc();
      ld_valid = 1'($urandom_range(0, 1));
      p_data   = 16'($urandom);
      shift_en = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 149) == 0);
    end
    cyc();
    reset    = 1'b0;
    ld_valid = 1'b0;
    shift_en = 1'b0;
    drain();
  endtask

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    p_data   = '0;
    shift_en = 1'b0;
    test_reset();
    test_lsb_a5();
    test_msb_odd();
    test_w5();
    test_back_to_back();
    test_ignored();
    test_reset_midword();
    test_random();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_tx_serializer_p

// File: doc/uart_tx_serializer_p.md
# uart_tx_serializer_p

Parametrised parallel-to-serial shifter for the UART transmit path, the next generation of the fixed 8-bit serializer. It accepts a word through a valid/ready handshake, shifts it out one bit per baud tick in a selectable bit order, and computes the word's parity at load. It sits between the UART TX controller FSM and the output mux that frames start, parity and stop bits. Zero-bubble back-to-back loads are supported.

## Interface
- DATA_WIDTH, 8, payload bits per word; legal range 2..16
- MSB_FIRST, 0, 0 = LSB first (UART standard), 1 = MSB first
- PAR_ODD, 0, 0 = even parity, 1 = odd parity

- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  p_data is valid and requests a load
- ld_ready  out  1  block can accept a load this cycle (combinational)
- p_data  in  DATA_WIDTH  parallel word, sampled only on acceptance
- shift_en  in  1  baud tick, one-cycle pulse, advances one bit
- ser_data  out  1  serial bit, registered
- ser_busy  out  1  word in flight, registered
- ser_done  out  1  one-cycle pulse after the last bit's period ends, registered
- par_bit  out  1  parity of the last accepted word, registered

## Operation
- States: IDLE, SHIFT.
- Reset values: state IDLE, ser_data 1 (line idle level), ser_busy 0, ser_done 0, par_bit 0, bit counter 0, shift register 0. ld_ready is 1 during reset.
- ld_ready = (state==IDLE) | (state==SHIFT & shift_en & cnt==DATA_WIDTH-1).
- Acceptance = ld_valid & ld_ready:
  - Capture p_data into the shift register.
  - Set cnt to 0 and par_bit to ^p_data ^ PAR_ODD.
  - Drive ser_data with the first bit (p_data[0], or p_data[DATA_WIDTH-1] if MSB_FIRST).
  - Set ser_busy to 1 and enter SHIFT.
- SHIFT with shift_en and cnt < DATA_WIDTH-1: increment cnt and present the next bit in order.
- SHIFT with shift_en and cnt == DATA_WIDTH-1: pulse ser_done. Then either:
  - no acceptance: state IDLE, ser_busy 0, ser_data 1;
  - acceptance in the same cycle: reload per the acceptance rule, ser_busy stays 1, and ser_data presents the new word's first bit.
- shift_en in IDLE is ignored. shift_en in the acceptance cycle from IDLE is ignored, so the first bit always gets a full tick period.
- ld_valid while ld_ready=0 is not accepted. The sender holds the request; the block has no error flag.
- p_data changes after acceptance have no effect on the word in flight.
- The counter is $clog2(DATA_WIDTH) bits wide and never exceeds DATA_WIDTH-1.
- Reset asserted mid-word aborts immediately to the reset values. No ser_done is produced.

## Timing
- Load at edge N: ser_data = first bit, ser_busy = 1, par_bit valid, all after edge N.
- k-th shift_en edge in SHIFT (k = 1..DATA_WIDTH-1): bit k is visible after that edge.
- Each bit is held from one shift_en edge to the next.
- DATA_WIDTH-th shift_en edge: ser_done = 1 for exactly one cycle.
- Load to done: DATA_WIDTH shift_en pulses. Throughput is one word per DATA_WIDTH ticks when back-to-back.
- ld_ready is combinational from state, cnt and shift_en. There is no combinational path from ld_valid to any output.

## Structure
- Shared package uart_pkg:
  - ser_state_e enum (IDLE, SHIFT);
  - UART_IDLE_LEVEL constant = 1'b1.
- Single module. Bit-order selection uses a generate on MSB_FIRST: right-shift for LSB first, left-shift for MSB first.
- No sub-module.

## Test plan
- LSB-first, W=8: load 8'hA5, then 8 ticks spaced 4 cycles apart -> ser_data sequence 1,0,1,0,0,1,0,1; par_bit 0; ser_done one cycle after the 8th tick; ser_data returns to 1.
- MSB_FIRST=1, PAR_ODD=1, W=8: load 8'h81 -> sequence 1,0,0,0,0,0,0,1; par_bit 1.
- Back-to-back, W=8: ld_valid held high with 8'h0F then 8'hF0, the second load accepted on the 8th tick -> ser_done pulses; ser_busy never drops; ser_data goes 1,1,1,1,0,0,0,0 then 0,0,0,0,1,1,1,1 with no idle gap.
- Ignored inputs: shift_en in IDLE and on the load cycle, ld_valid and a p_data change mid-word -> bit sequence unchanged; ld_ready 0 throughout SHIFT except on the last-tick cycle.
- Reset after the 3rd tick of 8'hFF -> ser_data 1, ser_busy 0, no ser_done. A following load of 8'h01 serialises correctly.
- W=5: load 5'b10110 -> sequence 0,1,1,0,1; done after 5 ticks; par_bit 1.
